// File: rtl/wb_commit_stage.sv
// Write-back/commit stage: registers one retiring instruction per cycle, drives RF write and IDU forwarding.
// Optional macro WB_COMMIT_PERF_CNT_EN builds the 64-bit retired-instruction counter; otherwise commit_cnt is 0.
module wb_commit_stage #(
  parameter int DATA_W = 64,
  parameter int PC_W   = 64,
  parameter int INST_W = 32,
  parameter int ADDR_W = 5,
  parameter int NSRC   = 3,
  parameter logic [INST_W-1:0] EBREAK_INST = 32'h0010_0073
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [PC_W-1:0]        in_pc,
  input  logic [INST_W-1:0]      in_inst,
  input  logic                   in_rd_ena,
  input  logic [ADDR_W-1:0]      in_rd_addr,
  input  logic [NSRC-1:0]        in_src_sel,
  input  logic [NSRC*DATA_W-1:0] in_src_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   fwd_valid,
  output logic [ADDR_W-1:0]      fwd_addr,
  output logic [DATA_W-1:0]      fwd_data,
  output logic                   commit_valid,
  output logic [PC_W-1:0]        commit_pc,
  output logic [INST_W-1:0]      commit_inst,
  output logic                   halt,
  output logic [63:0]            commit_cnt
);

  typedef enum logic {RUN, HALT} state_e;

  state_e              state_q;
  logic                valid_q;
  logic [PC_W-1:0]     pc_q;
  logic [INST_W-1:0]   inst_q;
  logic                rd_ena_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic [DATA_W-1:0]   data_q;
  logic [DATA_W-1:0]   data_d;
  logic                ebreak_retire;
  logic                load;

  // AND-OR mux: zero select yields 0, multi-hot select ORs the chosen sources.
  always_comb begin
    data_d = '0;
    for (int k = 0; k < NSRC; k++) begin
      data_d = data_d | (in_src_data[k*DATA_W +: DATA_W] & {DATA_W{in_src_sel[k]}});
    end
  end

  // The instruction offered while EBREAK retires is dropped so nothing commits after it.
  assign ebreak_retire = valid_q && (inst_q == EBREAK_INST);
  assign load          = in_valid && !ebreak_retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= RUN;
      valid_q   <= 1'b0;
      pc_q      <= '0;
      inst_q    <= '0;
      rd_ena_q  <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= '0;
    end else begin
      case (state_q)
        RUN: begin
          valid_q <= load;
          if (load) begin
            pc_q      <= in_pc;
            inst_q    <= in_inst;
            rd_ena_q  <= in_rd_ena;
            rd_addr_q <= in_rd_addr;
            data_q    <= data_d;
          end
          if (ebreak_retire) begin
            state_q <= HALT;
          end
        end
        HALT: begin
          valid_q <= 1'b0;
        end
        default: begin
          state_q <= RUN;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Gating with rst discards a held entry without writing when reset hits mid-operation.
  assign in_ready     = (state_q == RUN) && !rst;
  assign commit_valid = valid_q && !rst;
  assign commit_pc    = pc_q;
  assign commit_inst  = inst_q;
  assign rf_we        = commit_valid && rd_ena_q && (rd_addr_q != '0);
  assign rf_waddr     = rd_addr_q;
  assign rf_wdata     = data_q;
  assign fwd_valid    = rf_we;
  assign fwd_addr     = rd_addr_q;
  assign fwd_data     = data_q;
  assign halt         = (state_q == HALT);

`ifdef WB_COMMIT_PERF_CNT_EN
  logic [63:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (valid_q) begin
      cnt_q <= cnt_q + 64'd1;
    end
  end

  assign commit_cnt = cnt_q;
`else
  assign commit_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_commit_stage.sv
// Scoreboard bench for wb_commit_stage: driver pushes predicted commits, a negedge monitor pops and compares.
module tb_wb_commit_stage;

  localparam logic [31:0] EBREAK = 32'h0010_0073;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [63:0]  in_pc;
  logic [31:0]  in_inst;
  logic         in_rd_ena;
  logic [4:0]   in_rd_addr;
  logic [2:0]   in_src_sel;
  logic [191:0] in_src_data;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [63:0]  rf_wdata;
  logic         fwd_valid;
  logic [4:0]   fwd_addr;
  logic [63:0]  fwd_data;
  logic         commit_valid;
  logic [63:0]  commit_pc;
  logic [31:0]  commit_inst;
  logic         halt;
  logic [63:0]  commit_cnt;

  wb_commit_stage dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_inst(in_inst),
    .in_rd_ena(in_rd_ena), .in_rd_addr(in_rd_addr),
    .in_src_sel(in_src_sel), .in_src_data(in_src_data),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_data(fwd_data),
    .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
    .halt(halt), .commit_cnt(commit_cnt)
  );

  typedef struct {
    logic [63:0] pc;
    logic [31:0] inst;
    logic        we;
    logic [4:0]  waddr;
    logic [63:0] wdata;
    logic [63:0] cnt;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  bit          halted;
  bit          prev_eb;
  logic [63:0] cnt_m;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [63:0] exp_cnt(input logic [63:0] n);
`ifdef WB_COMMIT_PERF_CNT_EN
    return n;
`else
    return 64'd0;
`endif
  endfunction

  function automatic logic [63:0] pick(input logic [2:0] sel, input logic [191:0] src);
    logic [63:0] r;
    r = 64'd0;
    for (int k = 0; k < 3; k++) if (sel[k]) r = r | src[k*64 +: 64];
    return r;
  endfunction

  function automatic logic [191:0] rand_src();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  // One input cycle; the prediction is queued once the DUT has sampled it.
  task automatic step(input bit v, input logic [63:0] pc, input logic [31:0] inst, input bit rde,
                      input logic [4:0] rd, input logic [2:0] sel, input logic [191:0] src);
    exp_t e;
    bit   acc;
    in_valid = v; in_pc = pc; in_inst = inst; in_rd_ena = rde;
    in_rd_addr = rd; in_src_sel = sel; in_src_data = src;
    acc     = v && !halted && !prev_eb;
    halted  = halted || prev_eb;
    prev_eb = acc && (inst == EBREAK);
    e.pc = pc; e.inst = inst; e.we = rde && (rd != 5'd0); e.waddr = rd;
    e.wdata = pick(sel, src); e.cnt = cnt_m;
    if (acc) cnt_m = cnt_m + 64'd1;
    @(posedge clk); #1;
    if (acc) exp_q.push_back(e);
  endtask

  task automatic idle();
    step(1'b0, 64'd0, 32'd0, 1'b0, 5'd0, 3'd0, 192'd0);
  endtask

  task automatic rand_step(input int vld_pct);
    logic [31:0] inst;
    inst = $urandom;
    if (inst == EBREAK) inst = inst ^ 32'd1;
    step(($urandom_range(99) < vld_pct), {$urandom, $urandom}, inst, 1'($urandom),
         5'($urandom), 3'($urandom), rand_src());
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_commit_valid"}, 64'(commit_valid), 64'd0);
    chk({tag, "_rf_we"}, 64'(rf_we), 64'd0);
    chk({tag, "_fwd_valid"}, 64'(fwd_valid), 64'd0);
    chk({tag, "_halt"}, 64'(halt), 64'd0);
    chk({tag, "_rf_wdata"}, rf_wdata, 64'd0);
    chk({tag, "_rf_waddr"}, 64'(rf_waddr), 64'd0);
    chk({tag, "_commit_pc"}, commit_pc, 64'd0);
    chk({tag, "_commit_inst"}, 64'(commit_inst), 64'd0);
    chk({tag, "_commit_cnt"}, commit_cnt, 64'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1; in_valid = 1'b1; in_pc = {$urandom, $urandom}; in_inst = 32'h0000_0013;
    in_rd_ena = 1'b1; in_rd_addr = 5'd7; in_src_sel = 3'b010; in_src_data = rand_src();
    exp_q.delete(); halted = 1'b0; prev_eb = 1'b0; cnt_m = 64'd0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      if (i > 0) all_zero("rst");
      else chk("rst_commit_valid", 64'(commit_valid), 64'd0);
      @(posedge clk); #1;
    end
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    all_zero("post_rst");
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (commit_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_commit actual pc=%h inst=%h required=no_commit", commit_pc, commit_inst);
        end else begin
          e = exp_q.pop_front();
          chk("commit_pc", commit_pc, e.pc);
          chk("commit_inst", 64'(commit_inst), 64'(e.inst));
          chk("rf_we", 64'(rf_we), 64'(e.we));
          chk("fwd_valid", 64'(fwd_valid), 64'(e.we));
          chk("rf_waddr", 64'(rf_waddr), 64'(e.waddr));
          chk("fwd_addr", 64'(fwd_addr), 64'(e.waddr));
          chk("rf_wdata", rf_wdata, e.wdata);
          chk("fwd_data", fwd_data, e.wdata);
          chk("commit_cnt", commit_cnt, exp_cnt(e.cnt));
        end
      end else begin
        chk("idle_rf_we", 64'(rf_we), 64'd0);
        chk("idle_fwd_valid", 64'(fwd_valid), 64'd0);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [191:0] src;
    do_reset();

    // back-to-back EXU results
    for (int i = 0; i < 4; i++) begin
      src = rand_src();
      src[64 +: 64] = 64'h11 * (i + 1);
      step(1'b1, 64'h8000_0000 + 64'(4 * i), 32'h0000_0033, 1'b1, 5'(i + 1), 3'b010, src);
    end
    idle();
    chk("b2b_cnt", commit_cnt, exp_cnt(64'd4));

    // x0 destination and select corner cases
    step(1'b1, 64'h100, 32'h0000_0013, 1'b1, 5'd0, 3'b010, rand_src());
    step(1'b1, 64'h104, 32'h0000_0013, 1'b1, 5'd5, 3'b000, rand_src());
    src = rand_src();
    src[0 +: 64] = 64'hF0; src[64 +: 64] = 64'h0F;
    step(1'b1, 64'h108, 32'h0000_0013, 1'b1, 5'd6, 3'b011, src);
    idle();

    // bubble pattern 1,0,1
    do_reset();
    step(1'b1, 64'h200, 32'h0000_0013, 1'b1, 5'd1, 3'b001, rand_src());
    idle();
    step(1'b1, 64'h208, 32'h0000_0013, 1'b1, 5'd2, 3'b001, rand_src());
    idle();
    chk("bubble_cnt", commit_cnt, exp_cnt(64'd2));

    for (int i = 0; i < 400; i++) rand_step(75);
    idle();
    chk("rand_cnt", commit_cnt, exp_cnt(cnt_m));

    // EBREAK then a valid add that must never retire
    step(1'b1, 64'h300, EBREAK, 1'b0, 5'd0, 3'b010, rand_src());
    chk("eb_halt_before", 64'(halt), 64'd0);
    chk("eb_ready_before", 64'(in_ready), 64'd1);
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 64'h304, 32'h0020_81b3, 1'b1, 5'd3, 3'b010, rand_src());
      chk("eb_halt", 64'(halt), 64'd1);
      chk("eb_ready", 64'(in_ready), 64'd0);
    end
    idle();
    chk("eb_halt_sticky", 64'(halt), 64'd1);

    do_reset();
    for (int i = 0; i < 30; i++) rand_step(60);
    idle();
    idle();
    chk("final_cnt", commit_cnt, exp_cnt(cnt_m));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
